// File: rtl/disp_pkg.sv
// disp_pkg: shared types and constants for the seven-segment scan controller.
//   scan_state_t : scan FSM states (S_BLANK, S_SHOW, S_COMMIT)
//   ANODE_OFF    : inactive level of one common anode (anodes are active-low)
//   SEG_OFF      : all segments dark (segments are active-low)
//   nib2onehot   : hex nibble -> 16-bit one-hot decoder select
package disp_pkg;

    typedef enum logic [1:0] {
        S_BLANK  = 2'd0,
        S_SHOW   = 2'd1,
        S_COMMIT = 2'd2
    } scan_state_t;

    localparam logic       ANODE_OFF = 1'b1;
    localparam logic [6:0] SEG_OFF   = 7'b1111111;

    function automatic logic [15:0] nib2onehot(input logic [3:0] nib);
        return 16'h0001 << nib;
    endfunction

endpackage

// File: rtl/disp_ctrl.sv
// disp_ctrl: one-hot hex value to seven-segment pattern decoder.
//   disp_val [15:0] in  : one-hot select, bit n shows hex digit n
//   seg_out  [6:0]  out : segments {g,f,e,d,c,b,a}, active-low
// Anything other than exactly one bit set leaves the digit dark.
module disp_ctrl
    import disp_pkg::*;
(
    input  logic [15:0] disp_val,
    output logic [6:0]  seg_out
);

    always_comb begin
        seg_out = SEG_OFF;
        case (disp_val)
            16'h0001: seg_out = 7'b1000000; // 0
            16'h0002: seg_out = 7'b1111001; // 1
            16'h0004: seg_out = 7'b0100100; // 2
            16'h0008: seg_out = 7'b0110000; // 3
            16'h0010: seg_out = 7'b0011001; // 4
            16'h0020: seg_out = 7'b0010010; // 5
            16'h0040: seg_out = 7'b0000010; // 6
            16'h0080: seg_out = 7'b1111000; // 7
            16'h0100: seg_out = 7'b0000000; // 8
            16'h0200: seg_out = 7'b0010000; // 9
            16'h0400: seg_out = 7'b0001000; // A
            16'h0800: seg_out = 7'b0000011; // b
            16'h1000: seg_out = 7'b1000110; // C
            16'h2000: seg_out = 7'b0100001; // d
            16'h4000: seg_out = 7'b0000110; // E
            16'h8000: seg_out = 7'b0001110; // F
            default:  seg_out = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed, double-buffered seven-segment scanner.
//   clk, rst                  : single clock, synchronous active-high reset
//   wr_en/wr_ready            : write handshake (write when both high)
//   wr_digit, wr_val          : target digit index and hex nibble
//   digit_en [NUM_DIGITS]     : per-digit enable, 0 blanks that digit
//   seg_out [6:0]             : registered segment pattern, active-low
//   an_out [NUM_DIGITS]       : registered common anodes, active-low
//   frame_tick                : one-cycle pulse on the bank-commit cycle
// Optional (macro DISP_SCAN_DP_EN): wr_dp input stored with each digit,
// dp_out registered active-low decimal point.
// Writes land in the pending bank; the displayed bank is refreshed from it
// only in S_COMMIT, so a frame never mixes old and new digits.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DIV_W       = $clog2(REFRESH_DIV)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    output logic                          wr_ready,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_digit,
    input  logic [3:0]                    wr_val,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    output logic [6:0]                    seg_out,
    output logic [NUM_DIGITS-1:0]         an_out,
    output logic                          frame_tick
`ifdef DISP_SCAN_DP_EN
    ,
    input  logic                          wr_dp,
    output logic                          dp_out
`endif
);

    localparam int                    IDX_W      = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = {NUM_DIGITS{ANODE_OFF}};
    localparam logic [DIV_W-1:0]      CNT_LAST   = DIV_W'(REFRESH_DIV - 2);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t             state, state_d;
    logic [IDX_W-1:0]        idx, idx_d;
    logic [DIV_W-1:0]        cnt, cnt_d;
    logic [3:0]              pending [NUM_DIGITS];
    logic [3:0]              active  [NUM_DIGITS];
    logic                    show_en;
    logic [NUM_DIGITS-1:0]   an_d;
    logic [6:0]              dec_seg;
    logic                    wr_fire;

    // wr_ready is registered from state_d, so it is low exactly in S_COMMIT.
    assign wr_fire = wr_en && wr_ready && (int'(wr_digit) < NUM_DIGITS);

    disp_ctrl u_disp_ctrl (
        .disp_val (nib2onehot(active[idx])),
        .seg_out  (dec_seg)
    );

    // an_d is the anode pattern for the cycle after this edge, so the
    // registered anodes line up with the state they belong to.
    always_comb begin
        state_d = state;
        idx_d   = idx;
        cnt_d   = cnt;
        an_d    = AN_ALL_OFF;
        case (state)
            S_BLANK: begin
                state_d = S_SHOW;
                cnt_d   = '0;
                if (digit_en[idx]) an_d[idx] = ~ANODE_OFF;
            end
            S_SHOW: begin
                if (cnt == CNT_LAST) begin
                    cnt_d = '0;
                    if (idx == IDX_LAST) begin
                        state_d = S_COMMIT;
                    end else begin
                        idx_d   = idx + 1'b1;
                        state_d = S_BLANK;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                    if (show_en) an_d[idx] = ~ANODE_OFF;
                end
            end
            S_COMMIT: begin
                state_d = S_BLANK;
                idx_d   = '0;
            end
            default: begin
                state_d = S_BLANK;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_BLANK;
            idx        <= '0;
            cnt        <= '0;
            show_en    <= 1'b0;
            an_out     <= AN_ALL_OFF;
            seg_out    <= SEG_OFF;
            wr_ready   <= 1'b1;
            frame_tick <= 1'b0;
            pending    <= '{default: '0};
            active     <= '{default: '0};
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            cnt        <= cnt_d;
            an_out     <= an_d;
            wr_ready   <= (state_d != S_COMMIT);
            frame_tick <= (state_d == S_COMMIT);
            if (state == S_BLANK) begin
                seg_out <= dec_seg;
                show_en <= digit_en[idx];
            end
            if (wr_fire) pending[wr_digit] <= wr_val;
            if (state == S_COMMIT) active <= pending;
        end
    end

`ifdef DISP_SCAN_DP_EN
    logic pending_dp [NUM_DIGITS];
    logic active_dp  [NUM_DIGITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_dp <= '{default: 1'b0};
            active_dp  <= '{default: 1'b0};
            dp_out     <= 1'b1;
        end else begin
            if (wr_fire) pending_dp[wr_digit] <= wr_dp;
            if (state == S_COMMIT) active_dp <= pending_dp;
            if (state == S_BLANK) dp_out <= ~active_dp[idx];
        end
    end
`endif

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Time-multiplexed scan controller for the multi-digit seven-segment display in the guessing game. It holds one hex nibble per digit, shares a single `disp_ctrl` decoder among all digits, and drives the common anodes one digit at a time. It double-buffers digit values so updates take effect only at frame boundaries, which prevents tearing. It sits between the game logic (writer) and the board segment/anode pins.

## Interface
- `NUM_DIGITS`, 4: number of multiplexed digits (2–8).
- `REFRESH_DIV`, 100000: clock cycles per digit slot (≥ 2).
- `DIV_W`, `$clog2(REFRESH_DIV)`: width of the slot counter.
- `clk`  in  1  system clock; the block uses this single clock only.
- `rst`  in  1  reset, synchronous and active-high.
- `wr_en`  in  1  write request.
- `wr_ready`  out  1  write accept; a write occurs on a cycle where `wr_en && wr_ready`.
- `wr_digit`  in  `$clog2(NUM_DIGITS)`  target digit index.
- `wr_val`  in  4  hex nibble for the target digit.
- `digit_en`  in  `NUM_DIGITS`  per-digit enable; 0 blanks that digit.
- `seg_out`  out  7  segment pattern from `disp_ctrl`, registered.
- `an_out`  out  `NUM_DIGITS`  anodes, active-low, registered.
- `frame_tick`  out  1  one-cycle pulse on the commit cycle.

## Operation
- Two register banks of `NUM_DIGITS` × 4 bits each:
  - `pending` receives writes.
  - `active` is what the display shows.
- A write sets `pending[wr_digit] <= wr_val`.
  - Writes with `wr_digit >= NUM_DIGITS` are accepted and discarded.
  - Multiple writes to the same digit before a commit: the last one wins.
- Decoder input is the one-hot value `16'b1 << active[idx]`, fed to the single `disp_ctrl` instance.
- FSM states and transitions:
  - `S_BLANK` (1 cycle): sets `an_out` to all ones and loads `seg_out` with the decode of `active[idx]`. Samples `digit_en[idx]` into `show_en`. Goes to `S_SHOW`.
  - `S_SHOW` (`REFRESH_DIV-1` cycles): `an_out[idx]=0` if `show_en`, otherwise all ones. When the slot counter expires:
    - if `idx < NUM_DIGITS-1`: increment `idx`, go to `S_BLANK`;
    - otherwise go to `S_COMMIT`.
  - `S_COMMIT` (1 cycle): `active <= pending`, `frame_tick=1`, `wr_ready=0`, `an_out` all ones. Sets `idx=0` and goes to `S_BLANK`.
- `wr_ready` is 1 in every state except `S_COMMIT`.
- A write on the last `S_SHOW` cycle lands in `pending` and is committed in the immediately following `S_COMMIT`.
- A `digit_en` change takes effect at the next `S_BLANK` only.
- `rst` asserted mid-frame:
  - returns every register to its reset value on the next edge;
  - clears `pending` and `active`;
  - after release, scanning restarts at `S_BLANK`, `idx=0`.

## Timing
- Reset values:
  - `an_out` = all ones, `seg_out` = `7'b1111111`;
  - `wr_ready` = 1, `frame_tick` = 0;
  - state = `S_BLANK`, `idx` = 0, slot counter = 0, both banks = 0.
- Slot length is exactly `REFRESH_DIV` cycles: 1 blank plus `REFRESH_DIV-1` show.
- Frame length is `NUM_DIGITS*REFRESH_DIV + 1` cycles, so the `frame_tick` period equals that value.
- Write-to-display latency:
  - a write is visible no earlier than the `S_SHOW` of its digit in the frame after the next `frame_tick`;
  - worst case is 2 frames.
- Outputs are registered; `an_out` is never low during `S_BLANK` or `S_COMMIT`, which guarantees a ghost-free anode change.
- `seg_out` is stable throughout a slot's `S_SHOW` cycles.

## Configuration
- `DISP_SCAN_DP_EN` defined:
  - adds input `wr_dp` (1 bit), stored alongside `wr_val` in both banks;
  - adds output `dp_out` (1 bit, active-low, registered, reset 1);
  - `dp_out` is driven as `~active_dp[idx]` on the same cycles as `seg_out`.
- `DISP_SCAN_DP_EN` undefined: `wr_dp` and `dp_out` do not exist; the banks are 4 bits per digit.

## Structure
- Package `disp_pkg` holds:
  - the state enum typedef (`S_BLANK`, `S_SHOW`, `S_COMMIT`);
  - `ANODE_OFF` and `SEG_OFF` constants;
  - the function `nib2onehot(logic [3:0]) -> logic [15:0]`.
- Sub-module: one instance of the existing `disp_ctrl` decoder (`disp_val` in, `seg_out` out). The decoder is not duplicated per digit.

## Test plan
All scenarios use `REFRESH_DIV=4` and `NUM_DIGITS=4`.
- Reset: `rst=1` for 3 cycles -> `an_out=4'b1111`, `seg_out=7'b1111111`, `wr_ready=1`, `frame_tick=0`.
- Scan cadence:
  - measure the `frame_tick` period -> 17 cycles;
  - each slot gives `an_out=4'b1111` for 1 cycle, then `4'b1110`/`1101`/`1011`/`0111` for 3 cycles each.
- Double buffering:
  - write digit 0 = `4'h3` mid-frame -> the current frame still shows the old value;
  - after the next `frame_tick`, slot 0 gives `seg_out == disp_ctrl(16'h0008)` while `an_out=4'b1110`.
- Commit stall:
  - hold `wr_en` with digit 1 = `4'hA` into `S_COMMIT` -> `wr_ready=0` that cycle;
  - the write is accepted the next cycle and displayed one frame later.
- Blanking: `digit_en=4'b1011` -> `an_out[2]` stays 1 for the whole frame and the frame length is still 17 cycles.
- Mid-frame reset:
  - load digits {1,2,3,4} and commit, then assert `rst` during slot 2 -> outputs return to reset values next edge;
  - after release, every digit decodes `16'h0001`.
